// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package ldm_stm_sequencer_pkg;

   localparam int unsigned REG_IDX_W  = 4;
   localparam int unsigned WORD_BYTES = 4;

   // Encoding is {p_bit, u_bit}
   typedef enum logic [1:0] {
      DA = 2'b00,
      IA = 2'b01,
      DB = 2'b10,
      IB = 2'b11
   } addr_mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_e;

endpackage : ldm_stm_sequencer_pkg

// File: rtl/ldm_stm_sequencer_lsb_encoder16.sv
// Lowest-set-bit finder for a 16-bit register mask: index, one-hot of that bit, single-bit flag.
module lsb_encoder16
   import ldm_stm_sequencer_pkg::*;
(
   input  logic [15:0]          mask,
   output logic [REG_IDX_W-1:0] idx,
   output logic [15:0]          clr_onehot,
   output logic                 single
);

   always_comb begin
      idx = '0;
      // Scan high to low so the last hit is the lowest set bit
      for (int i = 15; i >= 0; i--) begin
         if (mask[i]) idx = REG_IDX_W'(i);
      end
      clr_onehot = mask & (~mask + 16'd1);
      single     = (mask != 16'd0) && ((mask & (mask - 16'd1)) == 16'd0);
   end

endmodule : lsb_encoder16

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM micro-op sequencer: expands a register list into one ascending-address
// transfer per cycle and produces the base-register writeback.
module ldm_stm_sequencer
   import ldm_stm_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned NREGS  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 stall,
   input  logic [NREGS-1:0]     reglist,
   input  logic [ADDR_W-1:0]    base,
   input  logic [REG_IDX_W-1:0] base_reg,
   input  logic                 is_load,
   input  logic                 p_bit,
   input  logic                 u_bit,
   input  logic                 w_bit,
   output logic                 busy,
   output logic                 uop_valid,
   output logic [REG_IDX_W-1:0] uop_reg,
   output logic [ADDR_W-1:0]    uop_addr,
   output logic                 uop_load,
   output logic                 uop_last,
   output logic                 wb_valid,
   output logic [ADDR_W-1:0]    wb_value,
   output logic                 pc_loaded
);

   localparam int unsigned CNT_W = $clog2(NREGS + 1);
   localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(WORD_BYTES);

   state_e               state, state_nx;
   logic [NREGS-1:0]     mask_q;
   logic [ADDR_W-1:0]    addr_q, wb_value_q;
   logic                 load_q, wb_en_q, r15_q;

   logic [CNT_W-1:0]     n_c;
   logic [ADDR_W-1:0]    n_bytes_c, start_addr_c, wb_calc_c;
   addr_mode_e           mode_c;
   logic                 accept_c;

   logic [REG_IDX_W-1:0] lsb_idx;
   logic [NREGS-1:0]     lsb_clr;
   logic                 lsb_single;

   lsb_encoder16 u_lsb (
      .mask       (mask_q),
      .idx        (lsb_idx),
      .clr_onehot (lsb_clr),
      .single     (lsb_single)
   );

   assign accept_c = (state == IDLE) && start && !stall && (reglist != '0);

   // Popcount and accept-time address arithmetic (modulo 2^ADDR_W)
   always_comb begin
      n_c = '0;
      for (int i = 0; i < NREGS; i++) n_c = n_c + CNT_W'(reglist[i]);
      n_bytes_c = ADDR_W'(n_c) * WORD_STEP;
      mode_c    = addr_mode_e'({p_bit, u_bit});
      case (mode_c)
         IA:      start_addr_c = base;
         IB:      start_addr_c = base + WORD_STEP;
         DA:      start_addr_c = base - n_bytes_c + WORD_STEP;
         DB:      start_addr_c = base - n_bytes_c;
         default: start_addr_c = base;
      endcase
      wb_calc_c = u_bit ? (base + n_bytes_c) : (base - n_bytes_c);
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept_c) state_nx = XFER;
         XFER:    if (!stall && lsb_single) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Latched transfer context; the base-register-in-list load case suppresses writeback
   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q     <= '0;
         addr_q     <= '0;
         wb_value_q <= '0;
         load_q     <= 1'b0;
         wb_en_q    <= 1'b0;
         r15_q      <= 1'b0;
      end else if (!stall) begin
         if (accept_c) begin
            mask_q     <= reglist;
            addr_q     <= start_addr_c;
            wb_value_q <= wb_calc_c;
            load_q     <= is_load;
            wb_en_q    <= w_bit && !(is_load && reglist[base_reg]);
            r15_q      <= reglist[NREGS-1];
         end else if (state == XFER) begin
            mask_q <= mask_q & ~lsb_clr;
            addr_q <= addr_q + WORD_STEP;
         end
      end
   end

   always_comb begin
      busy      = 1'b0;
      uop_valid = 1'b0;
      uop_reg   = '0;
      uop_addr  = '0;
      uop_load  = 1'b0;
      uop_last  = 1'b0;
      wb_valid  = 1'b0;
      wb_value  = '0;
      pc_loaded = 1'b0;
      case (state)
         IDLE: busy = start && (reglist != '0) && !reset;
         XFER: begin
            busy      = 1'b1;
            uop_valid = 1'b1;
            uop_reg   = lsb_idx;
            uop_addr  = addr_q;
            uop_load  = load_q;
            uop_last  = lsb_single;
            wb_valid  = lsb_single && wb_en_q;
            wb_value  = wb_value_q;
            pc_loaded = lsb_single && load_q && r15_q;
         end
         default: ;
      endcase
   end

endmodule : ldm_stm_sequencer

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: queue-based transfer model, directed
// literal scenarios, then randomized traffic with stalls, resets and ignored starts.
module tb_ldm_stm_sequencer;

   logic        clk, reset, start, stall, is_load, p_bit, u_bit, w_bit;
   logic [15:0] reglist;
   logic [31:0] base;
   logic [3:0]  base_reg;
   logic        busy, uop_valid, uop_load, uop_last, wb_valid, pc_loaded;
   logic [3:0]  uop_reg;
   logic [31:0] uop_addr, wb_value;

   ldm_stm_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall), .reglist(reglist),
      .base(base), .base_reg(base_reg), .is_load(is_load), .p_bit(p_bit),
      .u_bit(u_bit), .w_bit(w_bit), .busy(busy), .uop_valid(uop_valid),
      .uop_reg(uop_reg), .uop_addr(uop_addr), .uop_load(uop_load),
      .uop_last(uop_last), .wb_valid(wb_valid), .wb_value(wb_value),
      .pc_loaded(pc_loaded)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int          r;
      logic [31:0] a;
   } uop_t;

   // Model: the list of transfers still owed, plus per-sequence attributes
   uop_t        q[$];
   logic [31:0] m_wbv;
   logic        m_wb_en, m_pcl, m_load;
   int          n_pass, n_total;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      else
         n_pass++;
   endtask

   task automatic build_seq();
      int          n, k;
      logic [31:0] nb, low;
      n  = $countones(reglist);
      nb = 32'(n * 4);
      if (u_bit) low = p_bit ? base + 32'd4 : base;
      else       low = p_bit ? base - nb : base - nb + 32'd4;
      k = 0;
      for (int i = 0; i < 16; i++) begin
         if (reglist[i]) begin
            q.push_back('{i, low + 32'(4 * k)});
            k++;
         end
      end
      m_wbv   = u_bit ? base + nb : base - nb;
      m_wb_en = w_bit && !(is_load && reglist[base_reg]);
      m_pcl   = is_load && reglist[15];
      m_load  = is_load;
   endtask

   // Compare all outputs against the model, then advance the model across the coming edge
   task automatic check_cycle();
      bit inx, last;
      #1;
      inx  = (q.size() > 0);
      last = (q.size() == 1);
      chk("busy", 32'(busy), 32'(inx || (start && reglist != 16'd0 && !reset)));
      chk("uop_valid", 32'(uop_valid), 32'(inx));
      chk("uop_reg", 32'(uop_reg), inx ? 32'(q[0].r) : 32'd0);
      chk("uop_addr", uop_addr, inx ? q[0].a : 32'd0);
      chk("uop_load", 32'(uop_load), 32'(inx && m_load));
      chk("uop_last", 32'(uop_last), 32'(last));
      chk("wb_valid", 32'(wb_valid), 32'(last && m_wb_en));
      chk("wb_value", wb_value, inx ? m_wbv : 32'd0);
      chk("pc_loaded", 32'(pc_loaded), 32'(last && m_pcl));
      if (reset) begin
         q.delete();
      end else if (!stall) begin
         if (q.size() > 0)                     q.delete(0);
         else if (start && reglist != 16'd0)   build_seq();
      end
   endtask

   task automatic idle_inputs();
      start = 1'b0; stall = 1'b0; reset = 1'b0;
   endtask

   task automatic launch(input logic [15:0] l, input logic [31:0] b, input logic [3:0] br,
                         input logic ld, input logic p, input logic u, input logic w);
      @(negedge clk);
      idle_inputs();
      start = 1'b1; reglist = l; base = b; base_reg = br;
      is_load = ld; p_bit = p; u_bit = u; w_bit = w;
      check_cycle();
      chk("lit_busy_accept", 32'(busy), 32'd1);
   endtask

   task automatic lit_uop(input int r, input logic [31:0] a, input logic last);
      chk("lit_valid", 32'(uop_valid), 32'd1);
      chk("lit_reg", 32'(uop_reg), 32'(r));
      chk("lit_addr", uop_addr, a);
      chk("lit_last", 32'(uop_last), 32'(last));
   endtask

   task automatic step_lit(input int r, input logic [31:0] a, input logic last);
      @(negedge clk);
      idle_inputs();
      check_cycle();
      lit_uop(r, a, last);
   endtask

   task automatic step_idle();
      @(negedge clk);
      idle_inputs();
      check_cycle();
      chk("lit_idle_valid", 32'(uop_valid), 32'd0);
      chk("lit_idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      m_wbv = '0; m_wb_en = 1'b0; m_pcl = 1'b0; m_load = 1'b0;
      reset = 1'b1; start = 1'b0; stall = 1'b0; reglist = '0; base = '0;
      base_reg = '0; is_load = 1'b0; p_bit = 1'b0; u_bit = 1'b0; w_bit = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      start = 1'b1; reglist = 16'h00FF;
      check_cycle();
      chk("lit_reset_busy", 32'(busy), 32'd0);
      chk("lit_reset_valid", 32'(uop_valid), 32'd0);

      // STM IA
      launch(16'h000B, 32'h1000, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1);
      step_lit(0, 32'h1000, 1'b0);
      step_lit(1, 32'h1004, 1'b0);
      step_lit(3, 32'h1008, 1'b1);
      chk("lit_ia_wb_valid", 32'(wb_valid), 32'd1);
      chk("lit_ia_wb_value", wb_value, 32'h100C);
      step_idle();

      // LDM DB with R15
      launch(16'h8010, 32'h2000, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1);
      step_lit(4, 32'h1FF8, 1'b0);
      chk("lit_db_pcl_first", 32'(pc_loaded), 32'd0);
      step_lit(15, 32'h1FFC, 1'b1);
      chk("lit_db_wb_value", wb_value, 32'h1FF8);
      chk("lit_db_pcl", 32'(pc_loaded), 32'd1);
      step_idle();

      // LDM IB with base in list: no writeback
      launch(16'h0006, 32'h0100, 4'd2, 1'b1, 1'b1, 1'b1, 1'b1);
      step_lit(1, 32'h0104, 1'b0);
      step_lit(2, 32'h0108, 1'b1);
      chk("lit_ib_wb_valid", 32'(wb_valid), 32'd0);
      step_idle();

      // Full list DA with address wrap
      launch(16'hFFFF, 32'h0000_0010, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++)
         step_lit(i, 32'hFFFF_FFD4 + 32'(4 * i), (i == 15) ? 1'b1 : 1'b0);
      chk("lit_da_last_addr", uop_addr, 32'h0000_0010);
      chk("lit_da_wb_value", wb_value, 32'hFFFF_FFD0);
      step_idle();

      // Stall during the second uop, with an ignored start
      launch(16'h0007, 32'h0000_0000, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
      step_lit(0, 32'h0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         idle_inputs();
         stall = 1'b1; start = 1'b1; reglist = 16'h00F0;
         check_cycle();
         lit_uop(1, 32'h4, 1'b0);
      end
      step_lit(1, 32'h4, 1'b0);
      step_lit(2, 32'h8, 1'b1);
      step_idle();

      // Reset mid-sequence, then start with an empty list
      launch(16'h00FF, 32'h0000_0040, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1);
      step_lit(0, 32'h40, 1'b0);
      step_lit(1, 32'h44, 1'b0);
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      check_cycle();
      step_idle();
      @(negedge clk);
      idle_inputs();
      start = 1'b1; reglist = 16'h0000;
      check_cycle();
      chk("lit_empty_busy", 32'(busy), 32'd0);
      step_idle();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         reset    = ($urandom % 60) == 0;
         stall    = ($urandom % 5) == 0;
         start    = ($urandom % 3) == 0;
         case ($urandom % 8)
            0:       reglist = 16'h0000;
            1:       reglist = 16'h0001 << ($urandom % 16);
            2, 3:    reglist = 16'($urandom);
            default: reglist = 16'($urandom) & 16'($urandom) & 16'($urandom);
         endcase
         base     = ($urandom % 4 == 0) ? 32'($urandom % 64) : $urandom;
         base_reg = 4'($urandom);
         is_load  = 1'($urandom);
         p_bit    = 1'($urandom);
         u_bit    = 1'($urandom);
         w_bit    = 1'($urandom);
         check_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_ldm_stm_sequencer
